// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment scan: synchronises dis_sel/dis_seg, decodes digits to BCD
// and assembles 8-digit frames. Optional macro SEG_SCAN_CHANGE_EN enables the frame_changed flag.
module seg_scan_decoder #(
   parameter int STABLE_CYC     = 4,
   parameter int TIMEOUT_CYC    = 100000,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [7:0]  dis_sel,
   input  logic [6:0]  dis_seg,
   output logic [31:0] frame,
   output logic [15:0] score_out,
   output logic        frame_valid,
   output logic        stale,
   output logic        sel_err,
   output logic        seg_err,
   output logic        frame_changed
);

   localparam int CNT_W = $clog2(STABLE_CYC + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

   typedef enum logic {IDLE, ASSEM} state_t;

   logic [7:0]       sel_s1_reg, sel_s2_reg, sel_hold_reg;
   logic [6:0]       seg_s1_reg, seg_s2_reg, seg_hold_reg;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [TMO_W-1:0] tmo_reg, tmo_next;
   logic [31:0]      shadow_reg, shadow_next, frame_reg;
   logic [7:0]       seen_reg, seen_base;
   state_t           state_reg;
   logic             frame_valid_reg, stale_reg, sel_err_reg, seg_err_reg;

   logic             changed, stable_evt, accept, xfer, seg_bad;
   logic [7:0]       sel_act;
   logic [6:0]       seg_act;
   logic [3:0]       dec_nib;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 5'h00;
         7'h06:   decode = 5'h01;
         7'h5B:   decode = 5'h02;
         7'h4F:   decode = 5'h03;
         7'h66:   decode = 5'h04;
         7'h6D:   decode = 5'h05;
         7'h7D:   decode = 5'h06;
         7'h07:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h6F:   decode = 5'h09;
         7'h00:   decode = 5'h0F;
         default: decode = 5'h1E;
      endcase
   endfunction

   // Dwell counter: number of cycles the synchronised pair has held, inclusive of the current one.
   always_comb begin
      changed    = {sel_s2_reg, seg_s2_reg} != {sel_hold_reg, seg_hold_reg};
      cnt_next   = changed ? CNT_W'(1) : ((cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1);
      stable_evt = (cnt_next == CNT_MAX) && (changed || (cnt_reg != CNT_MAX));
      sel_act    = (SEL_ACTIVE_LOW != 0) ? ~sel_s2_reg : sel_s2_reg;
      seg_act    = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_reg : seg_s2_reg;
      {seg_bad, dec_nib} = decode(seg_act);
      accept     = stable_evt && $onehot(sel_act);
      tmo_next   = accept ? '0 : ((tmo_reg == TMO_MAX) ? TMO_MAX : tmo_reg + 1'b1);
      xfer       = (state_reg == ASSEM) && (seen_reg == 8'hFF);
      seen_base  = xfer ? 8'h00 : seen_reg;
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
      assign shadow_next[gi*4 +: 4] = (accept && sel_act[gi]) ? dec_nib : shadow_reg[gi*4 +: 4];
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sel_s1_reg   <= '0;
         sel_s2_reg   <= '0;
         sel_hold_reg <= '0;
         seg_s1_reg   <= '0;
         seg_s2_reg   <= '0;
         seg_hold_reg <= '0;
         cnt_reg      <= '0;
         tmo_reg      <= '0;
         shadow_reg   <= '0;
      end else begin
         sel_s1_reg   <= dis_sel;
         sel_s2_reg   <= sel_s1_reg;
         sel_hold_reg <= sel_s2_reg;
         seg_s1_reg   <= dis_seg;
         seg_s2_reg   <= seg_s1_reg;
         seg_hold_reg <= seg_s2_reg;
         cnt_reg      <= cnt_next;
         tmo_reg      <= tmo_next;
         shadow_reg   <= shadow_next;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         seen_reg        <= '0;
         frame_reg       <= '0;
         frame_valid_reg <= 1'b0;
         stale_reg       <= 1'b0;
         sel_err_reg     <= 1'b0;
         seg_err_reg     <= 1'b0;
      end else begin
         frame_valid_reg <= xfer;
         sel_err_reg     <= stable_evt && (sel_act != 8'h00) && !$onehot(sel_act);
         seg_err_reg     <= accept && seg_bad;
         if (xfer) begin
            frame_reg <= shadow_reg;
         end
         if (accept) begin
            stale_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  seen_reg  <= sel_act;
                  state_reg <= ASSEM;
               end else begin
                  seen_reg <= 8'h00;
               end
            end
            default: begin
               // An accept during transfer seeds the next frame rather than the outgoing one.
               if (accept) begin
                  seen_reg <= seen_base | sel_act;
               end else if (!xfer && (tmo_next == TMO_MAX)) begin
                  stale_reg <= 1'b1;
                  seen_reg  <= 8'h00;
                  state_reg <= IDLE;
               end else begin
                  seen_reg <= seen_base;
               end
            end
         endcase
      end
   end

`ifdef SEG_SCAN_CHANGE_EN
   logic have_frame_reg, frame_changed_reg;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         have_frame_reg    <= 1'b0;
         frame_changed_reg <= 1'b0;
      end else begin
         frame_changed_reg <= xfer && (!have_frame_reg || (shadow_reg != frame_reg));
         if (xfer) begin
            have_frame_reg <= 1'b1;
         end
      end
   end

   assign frame_changed = frame_changed_reg;
`else
   assign frame_changed = 1'b0;
`endif

   assign frame       = frame_reg;
   assign score_out   = frame_reg[15:0];
   assign frame_valid = frame_valid_reg;
   assign stale       = stale_reg;
   assign sel_err     = sel_err_reg;
   assign seg_err     = seg_err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: frame table plus hand-written dwell, sel-error and timeout sequences.
module tb_seg_scan_decoder;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [7:0]  dis_sel;
   logic [6:0]  dis_seg;
   logic [31:0] frame;
   logic [15:0] score_out;
   logic        frame_valid, stale, sel_err, seg_err, frame_changed;

   always #5 clk_in = ~clk_in;

   seg_scan_decoder #(
      .STABLE_CYC(4), .TIMEOUT_CYC(200), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk_in(clk_in), .rst(rst), .dis_sel(dis_sel), .dis_seg(dis_seg),
      .frame(frame), .score_out(score_out), .frame_valid(frame_valid), .stale(stale),
      .sel_err(sel_err), .seg_err(seg_err), .frame_changed(frame_changed)
   );

`ifdef SEG_SCAN_CHANGE_EN
   localparam bit CHG_EN = 1'b1;
`else
   localparam bit CHG_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] din;        // nibble i = value shown on digit i (E = bad pattern 7'h49, F = blank)
      logic [31:0] exp_frame;
      logic        exp_chg;
   } vec_t;

   typedef struct {
      logic [31:0] f;
      logic        c;
   } exp_t;

   vec_t        tbl [5];
   exp_t        exp_q [$];
   int          n_tests = 0, n_fail = 0;
   int          fv_cnt = 0, sel_err_cnt = 0, seg_err_cnt = 0, n_push = 0;
   logic [31:0] last_model = '0;
   bit          have_model = 1'b0;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: seg_of = 7'h3F;
         4'h1: seg_of = 7'h06;
         4'h2: seg_of = 7'h5B;
         4'h3: seg_of = 7'h4F;
         4'h4: seg_of = 7'h66;
         4'h5: seg_of = 7'h6D;
         4'h6: seg_of = 7'h7D;
         4'h7: seg_of = 7'h07;
         4'h8: seg_of = 7'h7F;
         4'h9: seg_of = 7'h6F;
         4'hE: seg_of = 7'h49;
         default: seg_of = 7'h00;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] f, input logic c);
      exp_t e;
      e.f = f;
      e.c = c;
      exp_q.push_back(e);
      last_model = f;
      have_model = 1'b1;
      n_push++;
   endtask

   function automatic logic model_chg(input logic [31:0] f);
      return CHG_EN && (!have_model || (f != last_model));
   endfunction

   // Called at a falling edge; leaves the pattern up for cyc rising edges.
   task automatic show(input int k, input logic [3:0] n, input int cyc);
      logic [7:0] one;
      one = 8'h01;
      dis_sel = ~(one << k);
      dis_seg = ~seg_of(n);
      repeat (cyc) @(negedge clk_in);
   endtask

   task automatic scan_range(input logic [31:0] d, input int lo, input int hi, input int dwell);
      for (int k = lo; k <= hi; k++) show(k, d[k*4 +: 4], dwell);
   endtask

   task automatic blank_all(input int cyc);
      dis_sel = 8'hFF;
      dis_seg = 7'h7F;
      repeat (cyc) @(negedge clk_in);
   endtask

   // Scoreboard consumer: every frame_valid pops one expected frame.
   always @(negedge clk_in) begin
      if (!rst) begin
         if (sel_err) sel_err_cnt++;
         if (seg_err) seg_err_cnt++;
         if (frame_valid) begin
            fv_cnt++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_frame: got %h expected none", frame);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("frame", frame, e.f);
               check("score_out", 32'(score_out), 32'(e.f[15:0]));
               check("frame_changed", 32'(frame_changed), 32'(e.c));
               $display("[TB] frame %h score %h changed %0b", frame, score_out, frame_changed);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fv0;
      tbl[0] = '{32'h0003_0000, 32'h0003_0000, 1'b1};
      tbl[1] = '{32'h0003_0000, 32'h0003_0000, 1'b0};
      tbl[2] = '{32'h0000_0012, 32'h0000_0012, 1'b1};
      tbl[3] = '{32'h01E3_4567, 32'h01E3_4567, 1'b1};
      tbl[4] = '{32'hFF45_6789, 32'hFF45_6789, 1'b1};

      rst     = 1'b1;
      dis_sel = 8'hFF;
      dis_seg = 7'h7F;
      repeat (3) @(negedge clk_in);
      check("rst_frame", frame, 32'h0);
      check("rst_score", 32'(score_out), 32'h0);
      check("rst_frame_valid", 32'(frame_valid), 32'h0);
      check("rst_stale", 32'(stale), 32'h0);
      check("rst_sel_err", 32'(sel_err), 32'h0);
      check("rst_seg_err", 32'(seg_err), 32'h0);
      check("rst_frame_changed", 32'(frame_changed), 32'h0);
      rst = 1'b0;
      blank_all(10);

      // Table: full scans, 20-cycle dwell per digit
      for (int i = 0; i < 5; i++) begin
         push_exp(tbl[i].exp_frame, CHG_EN & tbl[i].exp_chg);
         scan_range(tbl[i].din, 0, 7, 20);
      end
      check("seg_err_after_table", 32'(seg_err_cnt), 32'd1);
      check("stale_running", 32'(stale), 32'h0);

      // Short dwell on digit 2 must not be accepted
      fv0 = fv_cnt;
      push_exp(32'h7654_3410, model_chg(32'h7654_3410));
      scan_range(32'h7654_3410, 0, 1, 20);
      show(2, 4'h9, 3);
      scan_range(32'h7654_3410, 3, 7, 20);
      check("short_dwell_no_frame", 32'(fv_cnt), 32'(fv0));
      show(2, 4'h4, 20);
      check("short_dwell_then_frame", 32'(fv_cnt), 32'(fv0 + 1));

      // Two digit enables at once: one sel_err, sample dropped
      push_exp(32'h4433_2211, model_chg(32'h4433_2211));
      scan_range(32'h4433_2211, 0, 3, 20);
      dis_sel = 8'b1111_1100;
      dis_seg = ~seg_of(4'h7);
      repeat (10) @(negedge clk_in);
      check("sel_err_once", 32'(sel_err_cnt), 32'd1);
      scan_range(32'h4433_2211, 4, 7, 20);

      // Timeout mid-frame: partial frame discarded, stale until next accept
      scan_range(32'h0000_9999, 0, 3, 20);
      blank_all(250);
      check("stale_set", 32'(stale), 32'h1);
      fv0 = fv_cnt;
      push_exp(32'h4321_8765, model_chg(32'h4321_8765));
      show(4, 4'h1, 20);
      check("stale_cleared", 32'(stale), 32'h0);
      scan_range(32'h4321_8765, 5, 7, 20);
      check("partial_discarded", 32'(fv_cnt), 32'(fv0));
      scan_range(32'h4321_8765, 0, 3, 20);
      check("resume_frame", 32'(fv_cnt), 32'(fv0 + 1));

      blank_all(10);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      check("frame_count", 32'(fv_cnt), 32'(n_push));
      check("sel_err_total", 32'(sel_err_cnt), 32'd1);
      check("seg_err_total", 32'(seg_err_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
